pulse_sched: RTL and testbench
==============================

PULSE_SCHED -- requirements
Module: pulse_sched

Interface
- REQ-001: Parameter N, default 8, width of each requester value and of the output value.
- REQ-002: Parameter GAP, default 0, number of forced idle cycles after each issued pulse (0..15).
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: trig  input  4  per-requester trigger (button level); bit i belongs to requester i.
- REQ-006: in0, in1, in2, in3  input  N each  value of requester 0..3, captured on that requester's trigger falling edge.
- REQ-007: out  output  N  granted value during the pulse cycle, 0 otherwise.
- REQ-008: valid  output  1  high for exactly one clock per issued pulse.
- REQ-009: gnt  output  2  index of the granted requester while valid=1, 0 otherwise.
- REQ-010: pending  output  4  per-requester request-pending flags.
- REQ-011: ovf  output  1  sticky flag: a request was overwritten while still pending.

Function
- REQ-012: Per-requester registered previous trig (prv[i]); a falling edge is detected at a clk edge where prv[i]=1 and trig[i]=0.
- REQ-013: On a detected edge, the SHALL rule is: pending[i] set to 1 and val[i] loaded from in_i at that same clk edge.
- REQ-014: An edge on requester i while pending[i]=1 overwrites val[i] (latest value wins) and sets ovf=1; ovf stays set until reset.
- REQ-015: Arbiter state: IDLE (may grant) and HOLD (gap countdown); there is no other state.
- REQ-016: In IDLE with any pending bit set, the scheduler issues a grant at the next clk edge: out<=val[g], gnt<=g, valid<=1, pending[g]<=0.
- REQ-017: g is chosen round-robin: search pending starting at index ptr, ascending mod 4; after a grant ptr<=g+1 mod 4.
- REQ-018: End-to-end latency: a falling edge sampled at clk edge k, with the arbiter free and no competition, gives valid=1 in the cycle after edge k+1 (2 clocks).
- REQ-019: valid, out and gnt return to 0 at the clk edge following a pulse cycle unless a back-to-back grant is issued (GAP=0 only).
- REQ-020: GAP>0: after each grant the arbiter enters HOLD with cnt=GAP and decrements once per clock; it returns to IDLE when cnt reaches 1, so exactly GAP idle cycles separate pulses.
- REQ-021: GAP=0: HOLD is never entered; grants may occur on consecutive clocks.
- REQ-022: A new edge on requester g at the same clk edge as g's grant: the set wins, so pending[g]=1 with the new value, and the old value is the one output; ovf is not set.
- REQ-023: Edges on several requesters at the same clk edge are all captured; they are served in round-robin order, one per pulse.
- REQ-024: trig held low or high indefinitely produces no further requests; only 1->0 transitions count.

Reset
- REQ-025: While reset=1 at a clk edge: prv, pending, val, out, gnt, valid, ovf, cnt, ptr all become 0; the state becomes IDLE.
- REQ-026: Reset mid-operation discards all pending requests and any HOLD countdown; no pulse is issued in the cycle following reset.
- REQ-027: With prv reset to 0, trig held low across reset release generates no spurious request.

Verification
- REQ-028: N=8, GAP=0; in1=8'hA5; trig[1] 1->0 once -> exactly one cycle of valid=1, gnt=1, out=8'hA5, 2 clocks after the edge; out=0 otherwise.
- REQ-029: GAP=0; trig[0], trig[2] and trig[3] fall on the same clock with in0=1, in2=2, in3=3 -> pulses on consecutive clocks with out=1, 2, 3 (gnt 0, 2, 3); then pending=0.
- REQ-030: GAP=3; two simultaneous requests -> the second pulse is exactly 4 clocks after the first (3 idle cycles between).
- REQ-031: Requester 2 edges twice before service with in2=8'h11 then 8'h22 -> a single pulse with out=8'h22, and ovf=1 afterwards.
- REQ-032: Round-robin fairness: requesters 0 and 1 each re-trigger immediately after every grant for 8 pulses -> the gnt sequence alternates 0,1,0,1,... with no starvation.
- REQ-033: Reset asserted for 1 clock while pending=4'b0110 and HOLD is active -> all outputs are 0 next cycle; no pulse follows; trig held low through the release gives no request.

Source files
------------

// File: rtl/pulse_sched.sv
// pulse_sched: four-requester pulse scheduler.
//
// Each requester i has a button-level trigger trig[i]. A 1->0 transition
// latches in<i> and marks the request pending. A round-robin arbiter issues
// one single-cycle pulse per pending request. Optionally, GAP forced idle
// cycles follow each pulse.
//
// Ports
//   clk      : clock, all state updates on rising edge
//   reset    : synchronous, active-high reset
//   trig     : per-requester trigger levels (bit i = requester i)
//   in0..in3 : requester values, captured on that trigger's falling edge
//   out      : granted value during the pulse cycle, 0 otherwise
//   valid    : high for exactly one clock per issued pulse
//   gnt      : index of the granted requester while valid=1, 0 otherwise
//   pending  : per-requester request-pending flags
//   ovf      : sticky, a pending request was overwritten before service
module pulse_sched #(
    parameter int N   = 8,
    parameter int GAP = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   trig,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    output logic [N-1:0] out,
    output logic         valid,
    output logic [1:0]   gnt,
    output logic [3:0]   pending,
    output logic         ovf
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [3:0] GAP_CNT = 4'(GAP);

    state_t       state_reg, state_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic [1:0]   ptr_reg, ptr_next;
    logic [3:0]   prv_reg;
    logic [3:0]   pend_reg, pend_next;
    logic [N-1:0] val_reg [4];
    logic [N-1:0] val_next [4];
    logic [N-1:0] out_reg, out_next;
    logic         valid_reg, valid_next;
    logic [1:0]   gnt_reg, gnt_next;
    logic         ovf_reg, ovf_next;

    logic [N-1:0] in_arr [4];
    logic [3:0]   fall;
    logic         found;
    logic [1:0]   g_idx;

    assign in_arr[0] = in0;
    assign in_arr[1] = in1;
    assign in_arr[2] = in2;
    assign in_arr[3] = in3;

    assign fall = prv_reg & ~trig;

    // Round-robin search starting at ptr_reg. Iterating from the farthest
    // offset down lets the nearest pending requester win.
    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        g_idx = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_reg + 2'(k);
            if (pend_reg[idx]) begin
                found = 1'b1;
                g_idx = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
            prv_reg   <= '0;
            pend_reg  <= '0;
            out_reg   <= '0;
            valid_reg <= 1'b0;
            gnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                val_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
            prv_reg   <= trig;
            pend_reg  <= pend_next;
            out_reg   <= out_next;
            valid_reg <= valid_next;
            gnt_reg   <= gnt_next;
            ovf_reg   <= ovf_next;
            for (int i = 0; i < 4; i++) begin
                val_reg[i] <= val_next[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        pend_next  = pend_reg;
        val_next   = val_reg;
        out_next   = '0;
        valid_next = 1'b0;
        gnt_next   = '0;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (found) begin
                    out_next        = val_reg[g_idx];
                    gnt_next        = g_idx;
                    valid_next      = 1'b1;
                    pend_next[g_idx] = 1'b0;
                    ptr_next        = g_idx + 2'd1;
                    if (GAP != 0) begin
                        state_next = HOLD;
                        cnt_next   = GAP_CNT;
                    end
                end
            end
            HOLD: begin
                // Leaving at cnt=1 yields exactly GAP idle cycles between pulses.
                if (cnt_reg <= 4'd1) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Capture happens after the grant clears its bit. A new edge on the
        // requester being served therefore re-arms it without flagging ovf.
        for (int i = 0; i < 4; i++) begin
            if (fall[i]) begin
                if (pend_next[i]) begin
                    ovf_next = 1'b1;
                end
                pend_next[i] = 1'b1;
                val_next[i]  = in_arr[i];
            end
        end
    end

    assign out     = out_reg;
    assign valid   = valid_reg;
    assign gnt     = gnt_reg;
    assign pending = pend_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_pulse_sched.sv
// Testbench for pulse_sched. Two instances share all stimulus: instance 0
// uses GAP=0 and instance 1 uses GAP=3. A request-level model predicts every
// output on every cycle. Directed scenarios add literal expectations.
module tb_pulse_sched;

    logic       clk;
    logic       reset;
    logic [3:0] trig;
    logic [7:0] tb_in [4];

    logic [7:0] d_out [2];
    logic       d_valid [2];
    logic [1:0] d_gnt [2];
    logic [3:0] d_pending [2];
    logic       d_ovf [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        pulse_sched #(.N(8), .GAP(gi * 3)) u_dut (
            .clk(clk),
            .reset(reset),
            .trig(trig),
            .in0(tb_in[0]),
            .in1(tb_in[1]),
            .in2(tb_in[2]),
            .in3(tb_in[3]),
            .out(d_out[gi]),
            .valid(d_valid[gi]),
            .gnt(d_gnt[gi]),
            .pending(d_pending[gi]),
            .ovf(d_ovf[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Each request is a pending flag plus a value. A grant is allowed when
    // more than GAP clock edges have passed since the previous grant.
    logic [3:0] m_prv;
    logic [3:0] m_pend [2];
    logic [7:0] m_val [2][4];
    logic       m_ovf [2];
    int         m_ptr [2];
    int         m_since [2];
    logic       m_valid [2];
    logic [7:0] m_out [2];
    logic [1:0] m_gnt [2];
    bit         started = 1'b0;

    function automatic void model_step(int d, int gap);
        bit         found;
        logic [1:0] g;
        logic [1:0] idx;
        if (reset) begin
            m_pend[d]  = '0;
            m_ovf[d]   = 1'b0;
            m_ptr[d]   = 0;
            m_since[d] = 100;
            m_valid[d] = 1'b0;
            m_out[d]   = '0;
            m_gnt[d]   = '0;
            for (int i = 0; i < 4; i++) m_val[d][i] = '0;
            return;
        end
        if (m_since[d] < 100) m_since[d]++;
        found = 1'b0;
        g     = '0;
        if (m_since[d] > gap) begin
            for (int k = 0; k < 4; k++) begin
                idx = 2'((m_ptr[d] + k) % 4);
                if (!found && m_pend[d][idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
        if (found) begin
            m_valid[d]   = 1'b1;
            m_out[d]     = m_val[d][g];
            m_gnt[d]     = g;
            m_pend[d][g] = 1'b0;
            m_ptr[d]     = (int'(g) + 1) % 4;
            m_since[d]   = 0;
        end else begin
            m_valid[d] = 1'b0;
            m_out[d]   = '0;
            m_gnt[d]   = '0;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_prv[i] && !trig[i]) begin
                if (m_pend[d][i]) m_ovf[d] = 1'b1;
                m_pend[d][i] = 1'b1;
                m_val[d][i]  = tb_in[i];
            end
        end
    endfunction

    always @(posedge clk) begin
        model_step(0, 0);
        model_step(1, 3);
        if (reset) begin
            m_prv   = '0;
            started = 1'b1;
        end else begin
            m_prv = trig;
        end
    end

    // Compare process: every cycle, both instances, away from the edge.
    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("dut%0d valid", d), 32'(d_valid[d]), 32'(m_valid[d]));
                check($sformatf("dut%0d out", d), 32'(d_out[d]), 32'(m_out[d]));
                check($sformatf("dut%0d gnt", d), 32'(d_gnt[d]), 32'(m_gnt[d]));
                check($sformatf("dut%0d pending", d), 32'(d_pending[d]), 32'(m_pend[d]));
                check($sformatf("dut%0d ovf", d), 32'(d_ovf[d]), 32'(m_ovf[d]));
                if (d_valid[d])
                    $display("dut%0d t=%0t pulse gnt=%0d out=%02h", d, $time, d_gnt[d], d_out[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        trig  = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int t;
        int first_t;
        int n_pulse;
        int n_g2;
        int seq [8];

        reset = 1'b1;
        trig  = '0;
        for (int i = 0; i < 4; i++) tb_in[i] = '0;
        tick();
        tick();
        check("reset valid", 32'(d_valid[0]), 32'd0);
        check("reset out", 32'(d_out[0]), 32'd0);
        check("reset pending", 32'(d_pending[0]), 32'd0);
        check("reset ovf", 32'(d_ovf[0]), 32'd0);
        reset = 1'b0;
        tick();

        // Single request on requester 1: pulse two clocks after the edge.
        tb_in[1] = 8'hA5;
        trig[1]  = 1'b1;
        tick();
        trig[1] = 1'b0;
        tick();
        check("single pre valid", 32'(d_valid[0]), 32'd0);
        check("single pre pending", 32'(d_pending[0]), 32'h2);
        tick();
        check("single valid", 32'(d_valid[0]), 32'd1);
        check("single gnt", 32'(d_gnt[0]), 32'd1);
        check("single out", 32'(d_out[0]), 32'hA5);
        tick();
        check("single post valid", 32'(d_valid[0]), 32'd0);
        check("single post out", 32'(d_out[0]), 32'd0);

        // Three simultaneous requests served on consecutive clocks (GAP=0).
        do_reset();
        tb_in[0] = 8'd1;
        tb_in[2] = 8'd2;
        tb_in[3] = 8'd3;
        trig     = 4'b1101;
        tick();
        trig = '0;
        tick();
        tick();
        check("multi p0 gnt", 32'(d_gnt[0]), 32'd0);
        check("multi p0 out", 32'(d_out[0]), 32'd1);
        check("multi p0 valid", 32'(d_valid[0]), 32'd1);
        tick();
        check("multi p1 gnt", 32'(d_gnt[0]), 32'd2);
        check("multi p1 out", 32'(d_out[0]), 32'd2);
        tick();
        check("multi p2 gnt", 32'(d_gnt[0]), 32'd3);
        check("multi p2 out", 32'(d_out[0]), 32'd3);
        check("multi pending", 32'(d_pending[0]), 32'd0);

        // GAP=3: second pulse four clocks after the first.
        do_reset();
        trig = 4'b0011;
        tick();
        trig    = '0;
        first_t = -1;
        n_pulse = 0;
        for (t = 0; t < 20; t++) begin
            tick();
            if (d_valid[1]) begin
                n_pulse++;
                if (first_t < 0) first_t = t;
                else check("gap spacing", 32'(t - first_t), 32'd4);
            end
        end
        check("gap pulse count", 32'(n_pulse), 32'd2);

        // Double edge on requester 2 while the GAP=3 arbiter holds.
        do_reset();
        tb_in[2] = 8'h11;
        trig     = 4'b0101;
        tick();
        trig = '0;
        tick();
        trig[2] = 1'b1;
        tick();
        trig[2]  = 1'b0;
        tb_in[2] = 8'h22;
        n_g2     = 0;
        for (t = 0; t < 12; t++) begin
            tick();
            if (d_valid[1] && d_gnt[1] == 2'd2) begin
                n_g2++;
                check("ovw out", 32'(d_out[1]), 32'h22);
            end
        end
        check("ovw pulse count", 32'(n_g2), 32'd1);
        check("ovw ovf gap3", 32'(d_ovf[1]), 32'd1);
        check("same-edge ovf gap0", 32'(d_ovf[0]), 32'd0);

        // Fairness: requesters 0 and 1 re-trigger after every grant.
        do_reset();
        trig = 4'b0011;
        tick();
        trig    = '0;
        n_pulse = 0;
        for (t = 0; t < 100 && n_pulse < 8; t++) begin
            tick();
            trig = '0;
            if (d_valid[0]) begin
                seq[n_pulse] = int'(d_gnt[0]);
                n_pulse++;
                trig[d_gnt[0]] = 1'b1;
            end
        end
        check("rr pulse count", 32'(n_pulse), 32'd8);
        for (int k = 0; k < n_pulse; k++) check($sformatf("rr gnt %0d", k), 32'(seq[k]), 32'(k % 2));
        trig = '0;

        // Reset during HOLD with two requests still pending.
        do_reset();
        trig = 4'b0111;
        tick();
        trig = '0;
        tick();
        tick();
        check("rst-hold valid", 32'(d_valid[1]), 32'd1);
        check("rst-hold pending", 32'(d_pending[1]), 32'h6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst valid", 32'(d_valid[1]), 32'd0);
        check("rst out", 32'(d_out[1]), 32'd0);
        check("rst gnt", 32'(d_gnt[1]), 32'd0);
        check("rst pending", 32'(d_pending[1]), 32'd0);
        check("rst ovf", 32'(d_ovf[1]), 32'd0);
        n_pulse = 0;
        for (t = 0; t < 8; t++) begin
            tick();
            if (d_valid[1] || d_pending[1] != 4'd0) n_pulse++;
        end
        check("rst no activity", 32'(n_pulse), 32'd0);

        // Randomised traffic, checked only against the model.
        for (t = 0; t < 1500; t++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) trig[i] = ~trig[i];
                tb_in[i] = 8'($urandom);
            end
            reset = ($urandom_range(0, 199) == 0);
        end
        reset = 1'b0;
        trig  = '0;
        for (t = 0; t < 20; t++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
